// File: rtl/ov7670_fb_capture.sv
// ============================================================================
// ov7670_fb_capture : OV7670 RGB444 single-frame capture into a frame buffer.
// Optional macro CAPTURE_DECIM_EN: 640x480 source decimated 2:1 per axis.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ov7670_fb_capture #(
   parameter int NUM_PIXELS = 76800
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        capture_en,
   input  logic        vsync_i,
   input  logic        href_i,
   input  logic [7:0]  data_i,
   output logic [16:0] wraddr_o,
   output logic [11:0] dout_o,
   output logic        we_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        led_done,
   output logic        err_o
);

   localparam logic [16:0] C_NUM_PIX = 17'(NUM_PIXELS);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_FRAME = 2'd1,
      S_CAPTURE    = 2'd2,
      S_DONE       = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_vsync_d;
   logic        r_phase;
   logic [3:0]  r_byte0;
   logic [16:0] r_pix_cnt;
   logic [16:0] r_wraddr;
   logic [11:0] r_dout;
   logic        r_we;
   logic        r_frame_done;
   logic        r_led_done;
   logic        r_err;

   logic        w_vs_rise;
   logic        w_vs_fall;
   logic        w_arm;
   logic        w_start;
   logic        w_keep;

   assign w_vs_rise = vsync_i & ~r_vsync_d;
   assign w_vs_fall = ~vsync_i & r_vsync_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy_o       = 1'b0;
      w_arm        = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (capture_en) begin
               w_arm        = 1'b1;
               w_state_next = S_WAIT_FRAME;
            end
         end
         S_WAIT_FRAME: begin
            busy_o = 1'b1;
            if (w_vs_fall) begin
               w_start      = 1'b1;
               w_state_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            busy_o = 1'b1;
            if (w_vs_rise) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (!capture_en) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

`ifdef CAPTURE_DECIM_EN
   // Keep only even columns of even lines of the 640x480 source.
   logic [9:0] r_col;
   logic [8:0] r_line;
   logic       r_href_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_col    <= '0;
         r_line   <= '0;
         r_href_d <= 1'b0;
      end else begin
         r_href_d <= href_i;
         if (w_start) begin
            r_col  <= '0;
            r_line <= '0;
         end else if (r_state == S_CAPTURE) begin
            if (!href_i) begin
               r_col <= '0;
            end else if (r_phase) begin
               r_col <= r_col + 10'd1;
            end
            if (r_href_d && !href_i) begin
               r_line <= r_line + 9'd1;
            end
         end
      end
   end

   assign w_keep = ~r_col[0] & ~r_line[0];
`else
   assign w_keep = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vsync_d    <= 1'b0;
         r_phase      <= 1'b0;
         r_byte0      <= '0;
         r_pix_cnt    <= '0;
         r_wraddr     <= '0;
         r_dout       <= '0;
         r_we         <= 1'b0;
         r_frame_done <= 1'b0;
         r_led_done   <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_vsync_d    <= vsync_i;
         r_we         <= 1'b0;
         r_frame_done <= 1'b0;

         if (w_arm) begin
            r_led_done <= 1'b0;
            r_err      <= 1'b0;
            r_pix_cnt  <= '0;
         end

         if (r_state == S_CAPTURE) begin
            if (href_i) begin
               r_phase <= ~r_phase;
               if (!r_phase) begin
                  r_byte0 <= data_i[3:0];
               end else if (w_keep) begin
                  // A full buffer turns extra pixels into an error, never a wrap.
                  if (r_pix_cnt == C_NUM_PIX) begin
                     r_err <= 1'b1;
                  end else begin
                     r_we      <= 1'b1;
                     r_wraddr  <= r_pix_cnt;
                     r_dout    <= {r_byte0, data_i};
                     r_pix_cnt <= r_pix_cnt + 17'd1;
                  end
               end
            end else begin
               r_phase <= 1'b0;
            end

            if (w_vs_rise) begin
               r_frame_done <= 1'b1;
               r_led_done   <= 1'b1;
               if (r_pix_cnt != C_NUM_PIX) begin
                  r_err <= 1'b1;
               end
            end
         end else begin
            r_phase <= 1'b0;
         end
      end
   end

   assign wraddr_o     = r_wraddr;
   assign dout_o       = r_dout;
   assign we_o         = r_we;
   assign frame_done_o = r_frame_done;
   assign led_done     = r_led_done;
   assign err_o        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ov7670_fb_capture.sv
// ============================================================================
// tb_ov7670_fb_capture : directed table-driven bench, 12-pixel frame buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ov7670_fb_capture;

   localparam int NPIX = 12;

   logic        clk_i;
   logic        rst_ni;
   logic        capture_en;
   logic        vsync_i;
   logic        href_i;
   logic [7:0]  data_i;
   logic [16:0] wraddr_o;
   logic [11:0] dout_o;
   logic        we_o;
   logic        busy_o;
   logic        frame_done_o;
   logic        led_done;
   logic        err_o;

   ov7670_fb_capture #(.NUM_PIXELS(NPIX)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .capture_en   (capture_en),
      .vsync_i      (vsync_i),
      .href_i       (href_i),
      .data_i       (data_i),
      .wraddr_o     (wraddr_o),
      .dout_o       (dout_o),
      .we_o         (we_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o),
      .led_done     (led_done),
      .err_o        (err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [11:0] exp_dout;
   } vec_t;

   vec_t vecs [NPIX];

   int n_checks = 0;
   int n_errors = 0;
   int fd_cnt   = 0;
   int wr_addr [$];
   int wr_dout [$];

   always @(negedge clk_i) begin
      if (we_o) begin
         wr_addr.push_back(int'(wraddr_o));
         wr_dout.push_back(int'(dout_o));
      end
      if (frame_done_o) fd_cnt++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_dout.delete();
      fd_cnt = 0;
   endtask

   task automatic vs_high(input int n);
      vsync_i = 1'b1;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic vs_low();
      vsync_i = 1'b0;
      repeat (2) @(negedge clk_i);
   endtask

   // Pixel k of the frame carries table entry k mod NPIX; odd_line gets a stray byte.
   task automatic send_lines(input int lines, input int ppl, input int odd_line);
      int k;
      k = 0;
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            href_i = 1'b1;
            data_i = vecs[k % NPIX].b0;
            @(negedge clk_i);
            data_i = vecs[k % NPIX].b1;
            @(negedge clk_i);
            k++;
         end
         if (l == odd_line) begin
            data_i = 8'hFF;
            @(negedge clk_i);
         end
         href_i = 1'b0;
         data_i = 8'h00;
         repeat (3) @(negedge clk_i);
      end
   endtask

   task automatic check_writes(input string tag, input int exp_n);
      int n;
      chk({tag, "_nwrites"}, wr_addr.size(), exp_n);
      n = (wr_addr.size() < exp_n) ? wr_addr.size() : exp_n;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
         chk($sformatf("%s_dout%0d", tag, i), wr_dout[i], int'(vecs[i % NPIX].exp_dout));
      end
   endtask

   task automatic arm();
      capture_en = 1'b1;
      @(negedge clk_i);
   endtask

   initial begin
      vecs[0]  = '{8'h0A, 8'hBC, 12'hABC};
      vecs[1]  = '{8'hF1, 8'h23, 12'h123};
      vecs[2]  = '{8'h0F, 8'hFF, 12'hFFF};
      vecs[3]  = '{8'h00, 8'h00, 12'h000};
      vecs[4]  = '{8'hA5, 8'h5A, 12'h55A};
      vecs[5]  = '{8'h3C, 8'hC3, 12'hCC3};
      vecs[6]  = '{8'h07, 8'h89, 12'h789};
      vecs[7]  = '{8'hE0, 8'h01, 12'h001};
      vecs[8]  = '{8'h12, 8'h34, 12'h234};
      vecs[9]  = '{8'h9D, 8'h6E, 12'hD6E};
      vecs[10] = '{8'h4B, 8'h70, 12'hB70};
      vecs[11] = '{8'h08, 8'h0F, 12'h80F};

      rst_ni = 1'b0; capture_en = 1'b0; vsync_i = 1'b0; href_i = 1'b0; data_i = 8'h00;
      repeat (3) @(negedge clk_i);
      chk("rst_we", we_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_led", led_done, 0);
      chk("rst_err", err_o, 0);
      chk("rst_addr", wraddr_o, 0);
      chk("rst_dout", dout_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Unarmed frame: nothing is written.
      vs_high(3); vs_low(); send_lines(3, 4, -1); vs_high(4);
      chk("idle_nwrites", wr_addr.size(), 0);
      chk("idle_busy", busy_o, 0);

      // Arm while a frame is in progress; only the following frame is taken.
      vs_low(); send_lines(1, 2, -1);
      arm();
      chk("arm_busy", busy_o, 1);
      send_lines(2, 4, -1);
      chk("midframe_nwrites", wr_addr.size(), 0);
      vs_high(4); vs_low(); send_lines(3, 4, -1); vs_high(4);
      check_writes("f1", NPIX);
      chk("f1_fd", fd_cnt, 1);
      chk("f1_led", led_done, 1);
      chk("f1_err", err_o, 0);
      chk("f1_busy", busy_o, 0);
      vs_low(); send_lines(3, 4, -1); vs_high(4);
      chk("done_hold_nwrites", wr_addr.size(), NPIX);
      chk("done_hold_fd", fd_cnt, 1);
      capture_en = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("idle_led_held", led_done, 1);
      chk("idle_busy2", busy_o, 0);

      // Odd byte count on line 0; capture_en dropped while waiting.
      clear_log();
      arm();
      chk("rearm_led_clr", led_done, 0);
      capture_en = 1'b0;
      vs_low(); send_lines(3, 4, 0); vs_high(4);
      check_writes("odd", NPIX);
      chk("odd_fd", fd_cnt, 1);
      chk("odd_led", led_done, 1);
      chk("odd_err", err_o, 0);

      // Oversized frame: writes stop at the last address, error flagged.
      clear_log();
      arm(); capture_en = 1'b0;
      vs_low(); send_lines(3, 5, -1); vs_high(4);
      check_writes("ovf", NPIX);
      chk("ovf_lastaddr", wraddr_o, NPIX - 1);
      chk("ovf_err", err_o, 1);
      chk("ovf_led", led_done, 1);
      chk("ovf_fd", fd_cnt, 1);

      // Undersized frame.
      clear_log();
      arm(); capture_en = 1'b0;
      chk("short_err_clr", err_o, 0);
      vs_low(); send_lines(2, 4, -1); vs_high(4);
      check_writes("short", 8);
      chk("short_err", err_o, 1);
      chk("short_fd", fd_cnt, 1);

      // Reset in the middle of a write cycle abandons the frame.
      clear_log();
      arm(); capture_en = 1'b0;
      vs_low();
      href_i = 1'b1; data_i = vecs[0].b0;
      @(negedge clk_i);
      data_i = vecs[0].b1;
      @(posedge clk_i); #1;
      chk("prerst_we", we_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("midrst_we", we_o, 0);
      chk("midrst_busy", busy_o, 0);
      href_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      send_lines(3, 4, -1); vs_high(4); vs_low(); send_lines(3, 4, -1); vs_high(4);
      chk("rst_nwrites", wr_addr.size(), 0);
      chk("rst_fd", fd_cnt, 0);
      chk("rst_led2", led_done, 0);
      chk("rst_busy2", busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ov7670_fb_capture.md
OV7670_FB_CAPTURE -- requirements
Module: ov7670_fb_capture

Interface
REQ-001 SHALL provide parameter NUM_PIXELS, default 76800, the pixel count of one 320x240 frame-buffer frame.
REQ-002 SHALL provide port clk_i  input  1  camera pixel clock; the only clock, and all other inputs are synchronous to it.
REQ-003 SHALL provide port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port capture_en  input  1  level; requests capture of the next complete frame.
REQ-005 SHALL provide port vsync_i  input  1  camera frame sync; high between frames.
REQ-006 SHALL provide port href_i  input  1  camera line valid; data_i carries a byte on every high cycle.
REQ-007 SHALL provide port data_i  input  8  camera byte, RGB444 xRGB order.
REQ-008 SHALL provide port wraddr_o  output  17  frame-buffer write address.
REQ-009 SHALL provide port dout_o  output  12  RGB444 write pixel {R,G,B}.
REQ-010 SHALL provide port we_o  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-011 SHALL provide port busy_o  output  1  high in WAIT_FRAME and CAPTURE.
REQ-012 SHALL provide port frame_done_o  output  1  one-cycle pulse at end of a captured frame.
REQ-013 SHALL provide port led_done  output  1  sticky done, high in DONE.
REQ-014 SHALL provide port err_o  output  1  sticky; captured pixel count differed from NUM_PIXELS.

Function
REQ-015 SHALL implement states IDLE, WAIT_FRAME, CAPTURE, DONE.
REQ-016 SHALL move from IDLE to WAIT_FRAME when capture_en=1, clearing led_done, err_o, the pixel counter and the byte phase.
REQ-017 SHALL move from WAIT_FRAME to CAPTURE on a vsync_i falling edge (previous cycle 1, current cycle 0), so a frame already in progress is never partially captured.
REQ-018 In CAPTURE, SHALL toggle the byte phase on every href_i=1 cycle, store the phase-0 byte, and form a pixel on the phase-1 byte.
REQ-019 SHALL form the pixel as dout_o = {byte0[3:0], byte1[7:4], byte1[3:0]}.
REQ-020 SHALL assert we_o for exactly one cycle, in the cycle after the phase-1 byte is sampled, with wraddr_o equal to the pre-increment pixel count; the pixel count SHALL then increment by 1.
REQ-021 SHALL reset the byte phase to 0 whenever href_i=0, dropping any unpaired byte at line end without a write.
REQ-022 SHALL NOT write once the pixel count equals NUM_PIXELS; each further pixel SHALL set err_o, and the address SHALL NOT wrap.
REQ-023 SHALL move from CAPTURE to DONE on a vsync_i rising edge, pulsing frame_done_o for one cycle and setting led_done.
REQ-024 SHALL set err_o on that vsync_i rising edge if the pixel count is not NUM_PIXELS.
REQ-025 SHALL ignore capture_en deassertion during WAIT_FRAME or CAPTURE, and the frame SHALL complete.
REQ-026 SHALL stay in DONE while capture_en=1, and SHALL return to IDLE when capture_en=0, holding led_done and err_o until the next arm.
REQ-027 SHALL drive we_o=0 in every state except the REQ-020 write cycle.

Reset
REQ-028 On rst_ni=0, SHALL asynchronously force IDLE with wraddr_o=0, dout_o=0, we_o=0, busy_o=0, frame_done_o=0, led_done=0, err_o=0, pixel count 0, byte phase 0, and vsync history 0.
REQ-029 Reset mid-CAPTURE SHALL abandon the frame with no further writes, and SHALL require capture_en to rearm after release.

Configuration
REQ-030 With CAPTURE_DECIM_EN defined, SHALL accept a 640x480 source: count columns per line and lines per frame (line counter increments on href_i falling edge, cleared at capture start), and write only pixels with even column and even line index.
REQ-031 Without CAPTURE_DECIM_EN, SHALL write every pixel, and the line counter SHALL be absent.

Verification
REQ-032 Arm, then a 320x240 frame with every pixel bytes 0x0A,0xBC -> 76800 writes, address 0..76799, dout_o=0xABC, one frame_done_o pulse, led_done=1, err_o=0.
REQ-033 Arm mid-frame (vsync_i low) -> no writes until after the next vsync_i falling edge, then exactly one full frame captured.
REQ-034 Line carrying 641 bytes -> 320 writes for that line, last byte dropped, and the next line starts at phase 0.
REQ-035 Frame of 240 lines x 321 pixels -> writes stop at address 76799, err_o=1, done still reported.
REQ-036 rst_ni low for 1 cycle at pixel 1000 -> we_o=0 immediately, state IDLE, and no writes without rearm.
REQ-037 With CAPTURE_DECIM_EN, 640x480 frame with pixel value = (col mod 16) -> 76800 writes, all with even-column values.
